// File: rtl/rv_plic_core_v2.sv
// PLIC interrupt core: per-source gateways with queued-edge counting and
// per-target priority arbitration with registered outputs and single-winner claims.
module rv_plic_core_v2 #(
  parameter int N_SOURCE = 128,
  parameter int N_TARGET = 60,
  parameter int MAX_PRIO = 7,
  parameter int MAX_PEND = 15,
  parameter int SRCW     = $clog2(N_SOURCE + 1),
  localparam int PRIOW   = $clog2(MAX_PRIO + 1),
  localparam int CNTW    = $clog2(MAX_PEND + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_SOURCE-1:0]          irq_sources_i,
  input  logic [N_SOURCE-1:0]          le_i,
  input  logic [N_SOURCE*PRIOW-1:0]    prio_i,
  input  logic [N_TARGET*N_SOURCE-1:0] ie_i,
  input  logic [N_TARGET*PRIOW-1:0]    threshold_i,
  input  logic [N_TARGET-1:0]          claim_re_i,
  input  logic [N_TARGET-1:0]          complete_we_i,
  input  logic [N_TARGET*SRCW-1:0]     complete_id_i,
  output logic [N_TARGET*SRCW-1:0]     claim_id_o,
  output logic [N_SOURCE-1:0]          ip_o,
  output logic [N_TARGET-1:0]          eip_targets_o
);

  typedef enum logic [1:0] {IDLE, PEND, CLAIMED} gw_state_e;

  gw_state_e           state_q [N_SOURCE];
  logic [CNTW-1:0]     cnt_q   [N_SOURCE];
  logic [CNTW-1:0]     cnt_inc [N_SOURCE];
  logic [N_SOURCE-1:0] src_q;
  logic                primed_q;
  logic [N_SOURCE-1:0] edge_det;
  logic [N_SOURCE-1:0] claim;
  logic [N_SOURCE-1:0] complete;
  logic [SRCW-1:0]     best_id   [N_TARGET];
  logic [PRIOW-1:0]    best_prio [N_TARGET];
  logic [SRCW-1:0]     best_id_q [N_TARGET];
  logic                live;

  // primed_q suppresses a false edge from a line that is already high when reset releases
  assign edge_det = irq_sources_i & ~src_q & {N_SOURCE{primed_q}};

  always_comb begin
    for (int i = 0; i < N_SOURCE; i++) begin
      ip_o[i]    = (state_q[i] == PEND);
      cnt_inc[i] = (cnt_q[i] == CNTW'(MAX_PEND)) ? cnt_q[i] : cnt_q[i] + 1'b1;
    end
  end

  always_comb begin
    claim    = '0;
    complete = '0;
    for (int t = 0; t < N_TARGET; t++) begin
      for (int i = 0; i < N_SOURCE; i++) begin
        if (claim_re_i[t] && claim_id_o[t*SRCW +: SRCW] == SRCW'(i + 1))
          claim[i] = 1'b1;
        if (complete_we_i[t] && complete_id_i[t*SRCW +: SRCW] == SRCW'(i + 1))
          complete[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q    <= '0;
      primed_q <= 1'b0;
      for (int i = 0; i < N_SOURCE; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      src_q    <= irq_sources_i;
      primed_q <= 1'b1;
      for (int i = 0; i < N_SOURCE; i++) begin
        if (le_i[i]) begin
          case (state_q[i])
            IDLE: if (edge_det[i]) state_q[i] <= PEND;
            PEND: begin
              if (claim[i]) state_q[i] <= CLAIMED;
              if (edge_det[i]) cnt_q[i] <= cnt_inc[i];
            end
            CLAIMED: begin
              if (complete[i]) begin
                if (cnt_q[i] != '0) begin
                  state_q[i] <= PEND;
                  if (!edge_det[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
                end else if (edge_det[i]) begin
                  state_q[i] <= PEND;
                end else begin
                  state_q[i] <= IDLE;
                end
              end else if (edge_det[i]) begin
                cnt_q[i] <= cnt_inc[i];
              end
            end
            default: state_q[i] <= IDLE;
          endcase
        end else begin
          case (state_q[i])
            IDLE:    if (irq_sources_i[i]) state_q[i] <= PEND;
            PEND:    if (claim[i]) state_q[i] <= CLAIMED;
            CLAIMED: if (complete[i]) state_q[i] <= IDLE;
            default: state_q[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Strict '>' keeps the lowest ID on priority ties
  always_comb begin
    for (int t = 0; t < N_TARGET; t++) begin
      best_id[t]   = '0;
      best_prio[t] = '0;
      for (int i = 0; i < N_SOURCE; i++) begin
        if (ip_o[i] && ie_i[t*N_SOURCE + i] && prio_i[i*PRIOW +: PRIOW] > best_prio[t]) begin
          best_prio[t] = prio_i[i*PRIOW +: PRIOW];
          best_id[t]   = SRCW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eip_targets_o <= '0;
      for (int t = 0; t < N_TARGET; t++) best_id_q[t] <= '0;
    end else begin
      for (int t = 0; t < N_TARGET; t++) begin
        best_id_q[t]     <= best_id[t];
        eip_targets_o[t] <= best_prio[t] > threshold_i[t*PRIOW +: PRIOW];
      end
    end
  end

  // A lower-index target claiming the same ID this cycle wins; stale IDs read as 0
  always_comb begin
    claim_id_o = '0;
    live       = 1'b0;
    for (int t = 0; t < N_TARGET; t++) begin
      live = 1'b0;
      for (int i = 0; i < N_SOURCE; i++)
        if (best_id_q[t] == SRCW'(i + 1) && ip_o[i]) live = 1'b1;
      for (int u = 0; u < t; u++)
        if (claim_re_i[u] && best_id_q[u] == best_id_q[t]) live = 1'b0;
      if (live) claim_id_o[t*SRCW +: SRCW] = best_id_q[t];
    end
  end

endmodule

// File: tb/tb_rv_plic_core_v2.sv
// Directed self-checking bench for rv_plic_core_v2 on a small 8-source, 4-target instance.
module tb_rv_plic_core_v2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  irq_sources;
  logic [7:0]  le;
  logic [23:0] prio;
  logic [31:0] ie;
  logic [11:0] threshold;
  logic [3:0]  claim_re;
  logic [3:0]  complete_we;
  logic [15:0] complete_id;
  logic [15:0] claim_id;
  logic [7:0]  ip;
  logic [3:0]  eip;

  int n_cmp = 0;
  int n_bad = 0;

  rv_plic_core_v2 #(
    .N_SOURCE(8),
    .N_TARGET(4),
    .MAX_PRIO(7),
    .MAX_PEND(15)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .irq_sources_i (irq_sources),
    .le_i          (le),
    .prio_i        (prio),
    .ie_i          (ie),
    .threshold_i   (threshold),
    .claim_re_i    (claim_re),
    .complete_we_i (complete_we),
    .complete_id_i (complete_id),
    .claim_id_o    (claim_id),
    .ip_o          (ip),
    .eip_targets_o (eip)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    irq_sources = '0;
    le          = '0;
    prio        = '0;
    ie          = '0;
    threshold   = '0;
    claim_re    = '0;
    complete_we = '0;
    complete_id = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic claim_pulse(input int t);
    claim_re[t] = 1'b1;
    step();
    claim_re = '0;
  endtask

  task automatic complete_pulse(input int t, input logic [3:0] id);
    complete_we[t]       = 1'b1;
    complete_id[t*4 +: 4] = id;
    step();
    complete_we = '0;
    complete_id = '0;
  endtask

  task automatic pulse_src(input int i);
    irq_sources[i] = 1'b1;
    step();
    irq_sources[i] = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    #3;
    n_cmp++; if (ip !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_ip: got %0h expected 0", ip); end
    n_cmp++; if (eip !== 4'h0) begin n_bad++; $display("[TB] FAIL reset_eip: got %0h expected 0", eip); end
    n_cmp++; if (claim_id !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_claim_id: got %0h expected 0", claim_id); end
    rst_ni = 1'b1;
    step();
    step();
    n_cmp++; if (ip !== 8'h00) begin n_bad++; $display("[TB] FAIL idle_ip: got %0h expected 0", ip); end
    n_cmp++; if (eip !== 4'h0) begin n_bad++; $display("[TB] FAIL idle_eip: got %0h expected 0", eip); end
  endtask

  task automatic test_level();
    do_reset();
    prio[6 +: 3]     = 3'd5;
    ie[2]            = 1'b1;
    threshold[2:0]   = 3'd2;
    irq_sources[2]   = 1'b1;
    step();
    n_cmp++; if (ip[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_ip_n1: got %0b expected 1", ip[2]); end
    n_cmp++; if (eip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL level_eip_n1: got %0b expected 0", eip[0]); end
    step();
    n_cmp++; if (eip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_eip_n2: got %0b expected 1", eip[0]); end
    n_cmp++; if (claim_id[3:0] !== 4'd3) begin n_bad++; $display("[TB] FAIL level_claim_id: got %0d expected 3", claim_id[3:0]); end
    claim_pulse(0);
    n_cmp++; if (ip[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL level_ip_after_claim: got %0b expected 0", ip[2]); end
    n_cmp++; if (eip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_eip_c1: got %0b expected 1", eip[0]); end
    n_cmp++; if (claim_id[3:0] !== 4'd0) begin n_bad++; $display("[TB] FAIL level_stale_mask: got %0d expected 0", claim_id[3:0]); end
    step();
    n_cmp++; if (eip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL level_eip_c2: got %0b expected 0", eip[0]); end
    complete_pulse(0, 4'd3);
    n_cmp++; if (ip[2] !== 1'b0) begin n_bad++; $display("[TB] FAIL level_idle_after_complete: got %0b expected 0", ip[2]); end
    step();
    n_cmp++; if (ip[2] !== 1'b1) begin n_bad++; $display("[TB] FAIL level_repend: got %0b expected 1", ip[2]); end
  endtask

  task automatic test_edge();
    int  repends;
    logic done;
    do_reset();
    le[0]        = 1'b1;
    prio[2:0]    = 3'd3;
    ie[0]        = 1'b1;
    for (int k = 0; k < 5; k++) pulse_src(0);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (claim_id[3:0] !== 4'd1) begin n_bad++; $display("[TB] FAIL edge_claim_id_%0d: got %0d expected 1", k, claim_id[3:0]); end
      claim_pulse(0);
      n_cmp++; if (ip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_claimed_%0d: got %0b expected 0", k, ip[0]); end
      complete_pulse(0, 4'd1);
      n_cmp++; if (ip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_repend_%0d: got %0b expected 1", k, ip[0]); end
      step();
    end
    claim_pulse(0);
    complete_pulse(0, 4'd1);
    n_cmp++; if (ip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_final_idle: got %0b expected 0", ip[0]); end
    step();
    n_cmp++; if (ip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_stays_idle: got %0b expected 0", ip[0]); end
    for (int k = 0; k < 20; k++) pulse_src(0);
    repends = 0;
    done    = 1'b0;
    for (int k = 0; k < 25 && !done; k++) begin
      claim_pulse(0);
      complete_pulse(0, 4'd1);
      if (ip[0]) begin
        repends++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL edge_sat_bound: got %0b expected 1", done); end
    n_cmp++; if (repends !== 15) begin n_bad++; $display("[TB] FAIL edge_saturation: got %0d expected 15", repends); end
  endtask

  task automatic test_priority();
    do_reset();
    prio[3 +: 3]   = 3'd4;
    prio[18 +: 3]  = 3'd4;
    ie[1]          = 1'b1;
    ie[6]          = 1'b1;
    irq_sources[1] = 1'b1;
    irq_sources[6] = 1'b1;
    step();
    step();
    n_cmp++; if (ip !== 8'h42) begin n_bad++; $display("[TB] FAIL prio_ip: got %0h expected 42", ip); end
    n_cmp++; if (claim_id[3:0] !== 4'd2) begin n_bad++; $display("[TB] FAIL prio_tie: got %0d expected 2", claim_id[3:0]); end
    n_cmp++; if (eip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL prio_eip: got %0b expected 1", eip[0]); end
    prio[18 +: 3] = 3'd6;
    step();
    n_cmp++; if (claim_id[3:0] !== 4'd7) begin n_bad++; $display("[TB] FAIL prio_raise: got %0d expected 7", claim_id[3:0]); end
    threshold[2:0] = 3'd6;
    step();
    n_cmp++; if (eip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_threshold: got %0b expected 0", eip[0]); end
    threshold[2:0] = 3'd5;
    step();
    n_cmp++; if (eip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL prio_threshold_below: got %0b expected 1", eip[0]); end
  endtask

  task automatic test_multi_claim();
    do_reset();
    prio[12 +: 3]  = 3'd2;
    ie[4]          = 1'b1;
    ie[28]         = 1'b1;
    irq_sources[4] = 1'b1;
    step();
    irq_sources[4] = 1'b0;
    step();
    n_cmp++; if (claim_id[3:0] !== 4'd5) begin n_bad++; $display("[TB] FAIL multi_t0_before: got %0d expected 5", claim_id[3:0]); end
    n_cmp++; if (claim_id[15:12] !== 4'd5) begin n_bad++; $display("[TB] FAIL multi_t3_before: got %0d expected 5", claim_id[15:12]); end
    claim_re[0] = 1'b1;
    claim_re[3] = 1'b1;
    #1;
    n_cmp++; if (claim_id[3:0] !== 4'd5) begin n_bad++; $display("[TB] FAIL multi_t0_wins: got %0d expected 5", claim_id[3:0]); end
    n_cmp++; if (claim_id[15:12] !== 4'd0) begin n_bad++; $display("[TB] FAIL multi_t3_masked: got %0d expected 0", claim_id[15:12]); end
    step();
    claim_re = '0;
    n_cmp++; if (ip[4] !== 1'b0) begin n_bad++; $display("[TB] FAIL multi_claimed: got %0b expected 0", ip[4]); end
    complete_pulse(3, 4'd5);
    step();
    n_cmp++; if (ip[4] !== 1'b0) begin n_bad++; $display("[TB] FAIL multi_released_idle: got %0b expected 0", ip[4]); end
    n_cmp++; if (eip !== 4'h0) begin n_bad++; $display("[TB] FAIL multi_eip_idle: got %0h expected 0", eip); end
  endtask

  task automatic test_ignored();
    do_reset();
    prio[9 +: 3]   = 3'd1;
    ie[11]         = 1'b1;
    irq_sources[3] = 1'b1;
    step();
    irq_sources[3] = 1'b0;
    step();
    n_cmp++; if (claim_id[7:4] !== 4'd4) begin n_bad++; $display("[TB] FAIL ign_claim_id: got %0d expected 4", claim_id[7:4]); end
    n_cmp++; if (eip[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL ign_eip: got %0b expected 1", eip[1]); end
    complete_pulse(1, 4'd0);
    n_cmp++; if (ip !== 8'h08) begin n_bad++; $display("[TB] FAIL ign_complete_id0: got %0h expected 08", ip); end
    complete_pulse(1, 4'd9);
    n_cmp++; if (ip !== 8'h08) begin n_bad++; $display("[TB] FAIL ign_complete_id9: got %0h expected 08", ip); end
    complete_pulse(1, 4'd4);
    n_cmp++; if (ip !== 8'h08) begin n_bad++; $display("[TB] FAIL ign_complete_unclaimed: got %0h expected 08", ip); end
    n_cmp++; if (claim_id[11:8] !== 4'd0) begin n_bad++; $display("[TB] FAIL ign_t2_zero: got %0d expected 0", claim_id[11:8]); end
    claim_pulse(2);
    n_cmp++; if (ip !== 8'h08) begin n_bad++; $display("[TB] FAIL ign_claim_zero: got %0h expected 08", ip); end
    step();
    n_cmp++; if (claim_id[7:4] !== 4'd4) begin n_bad++; $display("[TB] FAIL ign_still_pending: got %0d expected 4", claim_id[7:4]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    le[0]     = 1'b1;
    prio[2:0] = 3'd3;
    ie[0]     = 1'b1;
    for (int k = 0; k < 4; k++) pulse_src(0);
    claim_pulse(0);
    n_cmp++; if (eip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_eip_before: got %0b expected 1", eip[0]); end
    irq_sources[0] = 1'b1;
    rst_ni         = 1'b0;
    #1;
    n_cmp++; if (ip !== 8'h00) begin n_bad++; $display("[TB] FAIL rmid_ip: got %0h expected 0", ip); end
    n_cmp++; if (eip !== 4'h0) begin n_bad++; $display("[TB] FAIL rmid_eip: got %0h expected 0", eip); end
    n_cmp++; if (claim_id !== 16'h0000) begin n_bad++; $display("[TB] FAIL rmid_claim_id: got %0h expected 0", claim_id); end
    step();
    step();
    rst_ni = 1'b1;
    step();
    step();
    step();
    n_cmp++; if (ip !== 8'h00) begin n_bad++; $display("[TB] FAIL rmid_held_high: got %0h expected 0", ip); end
    n_cmp++; if (eip !== 4'h0) begin n_bad++; $display("[TB] FAIL rmid_held_high_eip: got %0h expected 0", eip); end
    irq_sources[0] = 1'b0;
    step();
    irq_sources[0] = 1'b1;
    step();
    irq_sources[0] = 1'b0;
    n_cmp++; if (ip[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL rmid_new_edge: got %0b expected 1", ip[0]); end
    step();
    n_cmp++; if (claim_id[3:0] !== 4'd1) begin n_bad++; $display("[TB] FAIL rmid_claim_id_after: got %0d expected 1", claim_id[3:0]); end
    claim_pulse(0);
    complete_pulse(0, 4'd1);
    n_cmp++; if (ip[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL rmid_count_cleared: got %0b expected 0", ip[0]); end
  endtask

  initial begin
    rst_ni = 1'b0;
    clear_inputs();
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_multi_claim();
    test_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
